// File: rtl/gcn_agg_classify.sv
// Purpose: store transformed node rows, accumulate COO edges into saturating per-node sums, report per-node argmax class.
// Latency: start -> INIT (1 cycle) -> AGG (1 edge/cycle) -> CLASSIFY (NUM_NODES cycles) -> DONE (1 cycle pulse) -> IDLE.
// Backpressure: edge_ready is high only in AGG and comes from registered state; edges are held off in every other state.
module gcn_agg_classify #(
    parameter int NUM_NODES   = 6,
    parameter int NUM_CLASSES = 3,
    parameter int VALUE_WIDTH = 16,
    parameter int ACC_WIDTH   = 20,
    parameter int MAX_EDGES   = 64,
    parameter int NODE_BW     = $clog2(NUM_NODES),
    parameter int CLASS_BW    = $clog2(NUM_CLASSES),
    parameter int EDGE_BW     = $clog2(MAX_EDGES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [EDGE_BW-1:0]     num_edges,
    input  logic                   self_loop_en,
    input  logic                   fm_wr_en,
    input  logic [NODE_BW-1:0]     fm_wr_row,
    input  logic [VALUE_WIDTH-1:0] fm_wr_data [0:NUM_CLASSES-1],
    input  logic                   edge_valid,
    output logic                   edge_ready,
    input  logic [NODE_BW-1:0]     edge_src,
    input  logic [NODE_BW-1:0]     edge_dst,
    output logic                   busy,
    output logic                   done,
    output logic                   class_valid,
    output logic [NODE_BW-1:0]     class_node,
    output logic [CLASS_BW-1:0]    class_idx,
    output logic [CLASS_BW-1:0]    max_addi_answer [0:NUM_NODES-1],
    output logic                   overflow,
    output logic                   bad_edge
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_AGG,
        S_CLASSIFY,
        S_DONE
    } state_t;

    // One extra bit so a row/edge index can be range-checked even when NUM_NODES is a power of two.
    localparam logic [NODE_BW:0]   NODE_LIMIT = (NODE_BW + 1)'(NUM_NODES);
    localparam logic [NODE_BW-1:0] LAST_NODE  = NODE_BW'(NUM_NODES - 1);

    state_t                 state;
    state_t                 state_nxt;

    logic [VALUE_WIDTH-1:0] fm  [0:NUM_NODES-1][0:NUM_CLASSES-1];
    logic [ACC_WIDTH-1:0]   acc [0:NUM_NODES-1][0:NUM_CLASSES-1];

    logic [EDGE_BW-1:0]     num_edges_q;
    logic [EDGE_BW-1:0]     edge_cnt;
    logic                   self_loop_q;
    logic [NODE_BW-1:0]     cls_cnt;

    logic                   edge_fire;
    logic                   edge_ok;
    logic                   last_edge;
    logic                   last_node;
    logic                   wr_ok;

    logic [ACC_WIDTH:0]     sum_wide [0:NUM_CLASSES-1];
    logic [ACC_WIDTH-1:0]   sum_sat  [0:NUM_CLASSES-1];
    logic                   sat_any;

    logic [ACC_WIDTH-1:0]   best_val;
    logic [CLASS_BW-1:0]    best_idx;

    assign edge_fire = edge_valid && (state == S_AGG);
    assign edge_ok   = ({1'b0, edge_src} < NODE_LIMIT) && ({1'b0, edge_dst} < NODE_LIMIT);
    assign last_edge = (edge_cnt + EDGE_BW'(1)) == num_edges_q;
    assign last_node = (cls_cnt == LAST_NODE);
    assign wr_ok     = fm_wr_en && (state == S_IDLE) && ({1'b0, fm_wr_row} < NODE_LIMIT);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs; edge_ready depends on state alone.
    always_comb begin
        state_nxt   = state;
        edge_ready  = 1'b0;
        busy        = (state != S_IDLE);
        done        = 1'b0;
        class_valid = 1'b0;
        class_node  = '0;
        class_idx   = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                state_nxt = (num_edges_q == '0) ? S_CLASSIFY : S_AGG;
            end
            S_AGG: begin
                edge_ready = 1'b1;
                if (edge_valid && last_edge) begin
                    state_nxt = S_CLASSIFY;
                end
            end
            S_CLASSIFY: begin
                class_valid = 1'b1;
                class_node  = cls_cnt;
                class_idx   = best_idx;
                if (last_node) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Saturating add of the source row onto the destination accumulator row.
    always_comb begin
        sat_any = 1'b0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            sum_wide[c] = (ACC_WIDTH + 1)'(acc[edge_dst][c]) + (ACC_WIDTH + 1)'(fm[edge_src][c]);
            sum_sat[c]  = sum_wide[c][ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_wide[c][ACC_WIDTH-1:0];
            sat_any     = sat_any | sum_wide[c][ACC_WIDTH];
        end
    end

    // Argmax over the row being classified; strict compare keeps ties on the lowest class.
    always_comb begin
        best_val = acc[cls_cnt][0];
        best_idx = '0;
        for (int c = 1; c < NUM_CLASSES; c++) begin
            if (acc[cls_cnt][c] > best_val) begin
                best_val = acc[cls_cnt][c];
                best_idx = CLASS_BW'(c);
            end
        end
    end

    // Transformed-row store; writable only while idle, persists across runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NUM_NODES; n++) begin
                for (int c = 0; c < NUM_CLASSES; c++) begin
                    fm[n][c] <= '0;
                end
            end
        end else if (wr_ok) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                fm[fm_wr_row][c] <= fm_wr_data[c];
            end
        end
    end

    // Accumulators: seeded in INIT, updated per in-range edge in AGG.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NUM_NODES; n++) begin
                for (int c = 0; c < NUM_CLASSES; c++) begin
                    acc[n][c] <= '0;
                end
            end
        end else if (state == S_INIT) begin
            for (int n = 0; n < NUM_NODES; n++) begin
                for (int c = 0; c < NUM_CLASSES; c++) begin
                    acc[n][c] <= self_loop_q ? ACC_WIDTH'(fm[n][c]) : '0;
                end
            end
        end else if (edge_fire && edge_ok) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                acc[edge_dst][c] <= sum_sat[c];
            end
        end
    end

    // Run bookkeeping: latched config, counters, sticky flags and held per-node answers.
    always_ff @(posedge clk) begin
        if (reset) begin
            num_edges_q <= '0;
            self_loop_q <= 1'b0;
            edge_cnt    <= '0;
            cls_cnt     <= '0;
            overflow    <= 1'b0;
            bad_edge    <= 1'b0;
            for (int n = 0; n < NUM_NODES; n++) begin
                max_addi_answer[n] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_edges_q <= num_edges;
                        self_loop_q <= self_loop_en;
                        overflow    <= 1'b0;
                        bad_edge    <= 1'b0;
                        for (int n = 0; n < NUM_NODES; n++) begin
                            max_addi_answer[n] <= '0;
                        end
                    end
                end
                S_INIT: begin
                    edge_cnt <= '0;
                    cls_cnt  <= '0;
                end
                S_AGG: begin
                    if (edge_fire) begin
                        edge_cnt <= edge_cnt + EDGE_BW'(1);
                        if (!edge_ok) begin
                            bad_edge <= 1'b1;
                        end else if (sat_any) begin
                            overflow <= 1'b1;
                        end
                    end
                end
                S_CLASSIFY: begin
                    max_addi_answer[cls_cnt] <= best_idx;
                    if (!last_node) begin
                        cls_cnt <= cls_cnt + NODE_BW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
